// File: rtl/calc_operand_sequencer.sv
// calc_operand_sequencer
// Collects an A, B, OP token stream and drives the three operands into an
// external combinational calculator. It waits SETTLE_CYCLES clock cycles,
// then registers the calculator outputs as a response held under valid/ready.
module calc_operand_sequencer #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        abort,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    output logic [7:0]  calc_a,
    output logic [7:0]  calc_b,
    output logic [1:0]  calc_op,
    input  logic [15:0] calc_result,
    input  logic [7:0]  calc_remainder,
    input  logic        calc_error,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic [7:0]  rsp_remainder,
    output logic        rsp_error,
    output logic [7:0]  tx_count
);

    localparam logic [2:0] S_A      = 3'd0;
    localparam logic [2:0] S_B      = 3'd1;
    localparam logic [2:0] S_OP     = 3'd2;
    localparam logic [2:0] S_SETTLE = 3'd3;
    localparam logic [2:0] S_RESP   = 3'd4;

    // The counter runs down to zero; zero marks the last settle cycle.
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    logic [2:0]  r_state;
    logic [2:0]  w_next;
    logic [3:0]  r_cnt;
    logic [7:0]  r_a;
    logic [7:0]  r_b;
    logic [1:0]  r_op;
    logic [15:0] r_rsp_result;
    logic [7:0]  r_rsp_remainder;
    logic        r_rsp_error;
    logic [7:0]  r_tx_count;

    logic w_tok_acc;
    logic w_rsp_acc;
    logic w_op_legal;
    logic w_settle_done;

    assign in_ready      = (r_state == S_A) || (r_state == S_B) || (r_state == S_OP);
    assign rsp_valid     = (r_state == S_RESP);
    assign w_tok_acc     = in_valid && in_ready;
    assign w_rsp_acc     = rsp_valid && rsp_ready;
    assign w_op_legal    = (in_data[7:2] == 6'd0);
    assign w_settle_done = (r_cnt == 4'd0);

    assign calc_a        = r_a;
    assign calc_b        = r_b;
    assign calc_op       = r_op;
    assign rsp_result    = r_rsp_result;
    assign rsp_remainder = r_rsp_remainder;
    assign rsp_error     = r_rsp_error;
    assign tx_count      = r_tx_count;

    // Next-state decode; abort overrides everything, unknown encodings recover to S_A.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_A:      if (w_tok_acc) w_next = S_B;
            S_B:      if (w_tok_acc) w_next = S_OP;
            S_OP:     if (w_tok_acc) w_next = w_op_legal ? S_SETTLE : S_RESP;
            S_SETTLE: if (w_settle_done) w_next = S_RESP;
            S_RESP:   if (w_rsp_acc) w_next = S_A;
            default:  w_next = S_A;
        endcase
        if (abort) begin
            w_next = S_A;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_A;
        end else begin
            r_state <= w_next;
        end
    end

    // Operand registers load only on an accepted token that abort does not void.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a  <= 8'd0;
            r_b  <= 8'd0;
            r_op <= 2'd0;
        end else if (w_tok_acc && !abort) begin
            case (r_state)
                S_A:     r_a <= in_data;
                S_B:     r_b <= in_data;
                S_OP:    if (w_op_legal) r_op <= in_data[1:0];
                default: ;
            endcase
        end
    end

    // Settle counter: loaded on a legal OP token, counts down while settling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 4'd0;
        end else if (!abort) begin
            if ((r_state == S_OP) && w_tok_acc && w_op_legal) begin
                r_cnt <= SETTLE_LOAD;
            end else if ((r_state == S_SETTLE) && !w_settle_done) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    // Response capture: illegal opcode or calculator error yields a zeroed error response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_result    <= 16'd0;
            r_rsp_remainder <= 8'd0;
            r_rsp_error     <= 1'b0;
        end else if (!abort) begin
            if ((r_state == S_OP) && w_tok_acc && !w_op_legal) begin
                r_rsp_result    <= 16'd0;
                r_rsp_remainder <= 8'd0;
                r_rsp_error     <= 1'b1;
            end else if ((r_state == S_SETTLE) && w_settle_done) begin
                if (calc_error) begin
                    r_rsp_result    <= 16'd0;
                    r_rsp_remainder <= 8'd0;
                    r_rsp_error     <= 1'b1;
                end else begin
                    r_rsp_result    <= calc_result;
                    r_rsp_remainder <= calc_remainder;
                    r_rsp_error     <= 1'b0;
                end
            end
        end
    end

    // Delivered-response counter, wrapping at 8 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_count <= 8'd0;
        end else if (w_rsp_acc && !abort) begin
            r_tx_count <= r_tx_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_calc_operand_sequencer.sv
// Bench for calc_operand_sequencer: two instances (SETTLE_CYCLES 1 and 3)
// share the token stream; each has its own calculator stub and response ready.
module tb_calc_operand_sequencer;

    localparam int NI = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        abort;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready       [NI];
    logic [7:0]  calc_a         [NI];
    logic [7:0]  calc_b         [NI];
    logic [1:0]  calc_op        [NI];
    logic [15:0] calc_result    [NI];
    logic [7:0]  calc_remainder [NI];
    logic        calc_error     [NI];
    logic        rsp_valid      [NI];
    logic        rsp_ready      [NI];
    logic [15:0] rsp_result     [NI];
    logic [7:0]  rsp_remainder  [NI];
    logic        rsp_error      [NI];
    logic [7:0]  tx_count       [NI];

    int n_checks = 0;
    int n_errors = 0;
    int exp_tx [NI];
    logic [7:0] last_b;

    // Calculator stub: returns garbage on error so zero-forcing is observable.
    function automatic logic [24:0] calc_stub(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        case (op)
            2'd0: return {9'd0, 16'(a) + 16'(b)};
            2'd1: return {9'd0, 16'(a) - 16'(b)};
            2'd2: return {9'd0, 16'(a) * 16'(b)};
            default: begin
                if (b == 8'd0) return {1'b1, 8'hBE, 16'hDEAD};
                return {1'b0, a % b, 16'(a / b)};
            end
        endcase
    endfunction

    // Reference model of the expected response {error, remainder, result} for a token triple.
    function automatic logic [24:0] ref_rsp(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
        int unsigned r;
        if (op > 8'd3) return {1'b1, 24'd0};
        case (op)
            8'd0: r = (int'(a) + int'(b)) % 65536;
            8'd1: r = (65536 + int'(a) - int'(b)) % 65536;
            8'd2: r = int'(a) * int'(b);
            default: begin
                if (b == 0) return {1'b1, 24'd0};
                return {1'b0, 8'(int'(a) % int'(b)), 16'(int'(a) / int'(b))};
            end
        endcase
        return {1'b0, 8'd0, 16'(r)};
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        assign {calc_error[g], calc_remainder[g], calc_result[g]} = calc_stub(calc_a[g], calc_b[g], calc_op[g]);

        calc_operand_sequencer #(.SETTLE_CYCLES(g == 0 ? 1 : 3)) u_dut (
            .clk            (clk),
            .rst_n          (rst_n),
            .abort          (abort),
            .in_valid       (in_valid),
            .in_ready       (in_ready[g]),
            .in_data        (in_data),
            .calc_a         (calc_a[g]),
            .calc_b         (calc_b[g]),
            .calc_op        (calc_op[g]),
            .calc_result    (calc_result[g]),
            .calc_remainder (calc_remainder[g]),
            .calc_error     (calc_error[g]),
            .rsp_valid      (rsp_valid[g]),
            .rsp_ready      (rsp_ready[g]),
            .rsp_result     (rsp_result[g]),
            .rsp_remainder  (rsp_remainder[g]),
            .rsp_error      (rsp_error[g]),
            .tx_count       (tx_count[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("%s_in_ready%0d", tag, k), 32'(in_ready[k]), 32'd1);
            chk($sformatf("%s_operands%0d", tag, k), {14'd0, calc_a[k], calc_b[k], calc_op[k]}, 32'd0);
            chk($sformatf("%s_rsp%0d", tag, k), {6'd0, rsp_valid[k], rsp_error[k], rsp_remainder[k], rsp_result[k]}, 32'd0);
            chk($sformatf("%s_tx%0d", tag, k), 32'(tx_count[k]), 32'd0);
        end
    endtask

    task automatic send_tok(input logic [7:0] d);
        int guard;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        guard    = 0;
        while (!(in_ready[0] && in_ready[1]) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) chk("in_ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 8'd0;
    endtask

    task automatic resp_check(input int k, input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] op, input int stall);
        logic [24:0] e;
        int lat;
        int exp_lat;
        e       = ref_rsp(a, b, op);
        exp_lat = (op > 8'd3) ? 0 : (k == 0 ? 1 : 3);
        lat     = 0;
        @(negedge clk);
        while (!rsp_valid[k] && lat < 40) begin
            chk($sformatf("settle_operands%0d", k), {14'd0, calc_a[k], calc_b[k], calc_op[k]}, {14'd0, a, b, op[1:0]});
            chk($sformatf("settle_in_ready%0d", k), 32'(in_ready[k]), 32'd0);
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk($sformatf("latency%0d", k), lat, exp_lat);
        chk($sformatf("rsp_result%0d", k), 32'(rsp_result[k]), 32'(e[15:0]));
        chk($sformatf("rsp_remainder%0d", k), 32'(rsp_remainder[k]), 32'(e[23:16]));
        chk($sformatf("rsp_error%0d", k), 32'(rsp_error[k]), 32'(e[24]));
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("stall_rsp%0d", k), {6'd0, rsp_valid[k], rsp_error[k], rsp_remainder[k], rsp_result[k]}, {7'd1, e});
            chk($sformatf("stall_in_ready%0d", k), 32'(in_ready[k]), 32'd0);
        end
        rsp_ready[k] = 1'b1;
        @(posedge clk);
        exp_tx[k] = (exp_tx[k] + 1) % 256;
        #1;
        rsp_ready[k] = 1'b0;
        chk($sformatf("tx_count%0d", k), 32'(tx_count[k]), 32'(exp_tx[k]));
        chk($sformatf("post_hs_valid%0d", k), 32'(rsp_valid[k]), 32'd0);
        chk($sformatf("post_hs_in_ready%0d", k), 32'(in_ready[k]), 32'd1);
    endtask

    task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op, input int stall);
        send_tok(a);
        send_tok(b);
        last_b = b;
        send_tok(op);
        fork
            resp_check(0, a, b, op, stall);
            resp_check(1, a, b, op, stall);
        join
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        logic [7:0] rop;
        int guard;

        rst_n        = 1'b0;
        abort        = 1'b0;
        in_valid     = 1'b0;
        in_data      = 8'd0;
        rsp_ready[0] = 1'b0;
        rsp_ready[1] = 1'b0;
        exp_tx[0]    = 0;
        exp_tx[1]    = 0;
        last_b       = 8'd0;
        #1;
        chk_idle_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed arithmetic cases.
        run_txn(8'd200, 8'd100, 8'h00, 0);
        run_txn(8'd5,   8'd10,  8'h01, 0);
        run_txn(8'd7,   8'd0,   8'h03, 0);
        run_txn(8'd200, 8'd7,   8'h03, 0);
        run_txn(8'd13,  8'd11,  8'h02, 5);
        run_txn(8'd1,   8'd2,   8'h07, 2);

        // Abort coincident with the B token handshake.
        send_tok(8'd77);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'd99;
        abort    = 1'b1;
        @(posedge clk);
        #1;
        abort    = 1'b0;
        in_valid = 1'b0;
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("abort_b_in_ready%0d", k), 32'(in_ready[k]), 32'd1);
            chk($sformatf("abort_b_calc_b%0d", k), 32'(calc_b[k]), 32'(last_b));
            chk($sformatf("abort_b_calc_a%0d", k), 32'(calc_a[k]), 32'd77);
        end
        run_txn(8'd9, 8'd4, 8'h01, 0);

        // Abort coincident with the response handshake voids it.
        send_tok(8'd3);
        send_tok(8'd4);
        send_tok(8'h00);
        guard = 0;
        @(negedge clk);
        while (!rsp_valid[1] && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("abort_rsp_valid_seen", 32'(rsp_valid[0] && rsp_valid[1]), 32'd1);
        abort        = 1'b1;
        rsp_ready[0] = 1'b1;
        rsp_ready[1] = 1'b1;
        @(posedge clk);
        #1;
        abort        = 1'b0;
        rsp_ready[0] = 1'b0;
        rsp_ready[1] = 1'b0;
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("abort_rsp_tx%0d", k), 32'(tx_count[k]), 32'(exp_tx[k]));
            chk($sformatf("abort_rsp_valid%0d", k), 32'(rsp_valid[k]), 32'd0);
            chk($sformatf("abort_rsp_in_ready%0d", k), 32'(in_ready[k]), 32'd1);
        end

        // Asynchronous reset pulse while both instances are settling.
        send_tok(8'd50);
        send_tok(8'd60);
        send_tok(8'h02);
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle_zero("mid_reset");
        @(negedge clk);
        rst_n     = 1'b1;
        exp_tx[0] = 0;
        exp_tx[1] = 0;

        // Randomized traffic, crossing the 8-bit wrap of tx_count.
        for (int i = 0; i < 260; i++) begin
            ra  = 8'($urandom);
            rb  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            rop = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(4, 255)) : 8'($urandom_range(0, 3));
            run_txn(ra, rb, rop, int'($urandom_range(0, 3)));
            if (i == 255) begin
                for (int k = 0; k < NI; k++) begin
                    chk($sformatf("tx_wrap%0d", k), 32'(tx_count[k]), 32'd0);
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
